seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 start  input  1  request; sampled only in IDLE.
REQ-004 op1  input  16  left operand, unsigned.
REQ-005 op2  input  16  right operand, unsigned.
REQ-006 operator  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-007 result  output  16  registered result: quotient for div, low 16 bits otherwise.
REQ-008 remainder  output  16  registered remainder; div only, 0 for other ops.
REQ-009 busy  output  1  high while state is DIV; drives the controller's is_div wait loop.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 overflow  output  1  sub borrow or mul high-half nonzero; valid with done, held after.
REQ-012 div_by_zero  output  1  div with op2 == 0; valid with done, held after.

Function
REQ-013 The block SHALL implement three states, IDLE, DIV and DONE, encoded in a registered state variable.
REQ-014 IDLE, start=1, operator != 11: at that edge, result/remainder/flags SHALL be registered and the state SHALL go to DONE.
REQ-015 Add SHALL set result = (op1+op2) mod 2^16, with overflow = carry out of bit 15.
REQ-016 Sub SHALL set result = (op1-op2) mod 2^16, with overflow = 1 iff op1 < op2.
REQ-017 Mul SHALL set result = low 16 bits of the 32-bit product, with overflow = 1 iff the high 16 bits != 0.
REQ-018 IDLE, start=1, operator=11, op2 != 0: operands SHALL be latched internally, a 4-bit step counter cleared, and the state SHALL go to DIV.
REQ-019 DIV SHALL perform one restoring-division step per edge, quotient bits MSB first, for exactly 16 edges (counter 0..15).
REQ-020 On the 16th DIV edge, quotient and remainder SHALL be registered and the state SHALL go to DONE; div latency = 17 edges from the start edge to the edge that leaves DONE.
REQ-021 IDLE, start=1, operator=11, op2=0: the state SHALL go to DONE directly, with result=16'hFFFF, remainder=op1, div_by_zero=1 and overflow=0.
REQ-022 done SHALL be 1 only in DONE, which lasts exactly one cycle and then always returns to IDLE.
REQ-023 busy SHALL be 1 only in DIV, i.e. 16 cycles for a valid div and 0 cycles otherwise.
REQ-024 start SHALL be ignored in DIV and DONE, and a start held high SHALL begin a new operation on the first IDLE cycle.
REQ-025 Operand or operator changes during DIV SHALL NOT affect the running division.
REQ-026 result, remainder, overflow and div_by_zero SHALL hold their values until the next completion overwrites them.
REQ-027 For non-div ops remainder SHALL be written 0 and div_by_zero SHALL be written 0.

Reset
REQ-028 With rst=1 at an edge, the state SHALL be IDLE, the step counter 0, result=0, remainder=0, busy=0, done=0, overflow=0 and div_by_zero=0.
REQ-029 rst SHALL take priority over start and over any DIV step, and an in-progress division SHALL be abandoned with no done pulse.

Verification
REQ-030 op1=25, op2=17, add, start 1 cycle -> done high in the next cycle, result=42, overflow=0, busy never high.
REQ-031 op1=5, op2=7, sub -> result=16'hFFFE, overflow=1; then 300*300 mul -> result=16'h5F90, overflow=1.
REQ-032 op1=999, op2=7, div -> busy high exactly 16 cycles, done in the 17th cycle, result=142, remainder=5.
REQ-033 op1=1234, op2=0, div -> no busy, done next cycle, result=16'hFFFF, remainder=1234, div_by_zero=1.
REQ-034 div 60000/3 started, op2 changed to 9 and start pulsed in cycle 5 -> result=20000, remainder=0, exactly one done.
REQ-035 rst asserted in cycle 8 of a division -> next cycle busy=0, done=0, result=0, and the following add 1+1 returns 2.

Source files
------------

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between a controller and the sequential ALU
interface seq_alu_if;
    logic        start;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [1:0]  operator;
    logic [15:0] result;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        div_by_zero;
    modport master (
        output start, op1, op2, operator,
        input  result, remainder, busy, done, overflow, div_by_zero
    );
    modport slave (
        input  start, op1, op2, operator,
        output result, remainder, busy, done, overflow, div_by_zero
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: single-cycle add/sub/mul and 16-step restoring divide behind an IDLE/DIV/DONE FSM
module seq_alu (
    input logic      clk,
    input logic      rst,
    seq_alu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [15:0] q, r, d, nq, nr;
    logic [16:0] trial, diff, sum;
    logic [31:0] prod;
    logic        div_go;
    always_comb begin
        sum    = {1'b0, bus.op1} + {1'b0, bus.op2};
        prod   = bus.op1 * bus.op2;
        div_go = bus.operator == 2'b11 && bus.op2 != 16'd0;
        trial  = {r, q[15]};
        diff   = trial - {1'b0, d};
        nq     = {q[14:0], ~diff[16]};
        nr     = diff[16] ? trial[15:0] : diff[15:0];
    end
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_comb
        state_nx = state == IDLE ? (bus.start ? (div_go ? DIV : DONE) : IDLE) :
                   state == DIV  ? (cnt == 4'd15 ? DONE : DIV) : IDLE;
    always_comb begin
        bus.busy = state == DIV;
        bus.done = state == DONE;
    end
    // A valid divide leaves the visible outputs untouched until its last step
    always_ff @(posedge clk)
        if (rst) begin
            cnt             <= '0;
            q               <= '0;
            r               <= '0;
            d               <= '0;
            bus.result      <= '0;
            bus.remainder   <= '0;
            bus.overflow    <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            cnt <= '0;
            q   <= bus.op1;
            r   <= '0;
            d   <= bus.op2;
            if (!div_go) begin
                bus.result      <= bus.operator == 2'b00 ? sum[15:0] :
                                   bus.operator == 2'b01 ? bus.op1 - bus.op2 :
                                   bus.operator == 2'b10 ? prod[15:0] : 16'hFFFF;
                bus.remainder   <= bus.operator == 2'b11 ? bus.op1 : 16'd0;
                bus.overflow    <= bus.operator == 2'b00 ? sum[16] :
                                   bus.operator == 2'b01 ? bus.op1 < bus.op2 :
                                   bus.operator == 2'b10 ? |prod[31:16] : 1'b0;
                bus.div_by_zero <= bus.operator == 2'b11;
            end
        end else if (state == DIV) begin
            cnt <= cnt + 4'd1;
            q   <= nq;
            r   <= nr;
            if (cnt == 4'd15) begin
                bus.result      <= nq;
                bus.remainder   <= nr;
                bus.overflow    <= 1'b0;
                bus.div_by_zero <= 1'b0;
            end
        end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu against an arithmetic reference model
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    seq_alu_if bus ();
    seq_alu u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o,
                                  output logic [15:0] res, output logic [15:0] rem,
                                  output logic ov, output logic dz, output int lat_busy);
        int unsigned x = a, y = b, t;
        rem = 16'd0; dz = 1'b0; ov = 1'b0; lat_busy = 0;
        case (o)
            2'd0: begin t = x + y; res = 16'(t % 65536); ov = t > 65535; end
            2'd1: begin t = x + 65536 - y; res = 16'(t % 65536); ov = x < y; end
            2'd2: begin t = x * y; res = 16'(t % 65536); ov = t > 65535; end
            default:
                if (y == 0) begin res = 16'hFFFF; rem = a; dz = 1'b1; end
                else begin res = 16'(x / y); rem = 16'(x % y); lat_busy = 16; end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [1:0] o);
        logic [15:0] er, erem;
        logic        eov, edz;
        int          eb, nb;
        bit          seen;
        model(a, b, o, er, erem, eov, edz, eb);
        @(negedge clk);
        bus.op1 = a; bus.op2 = b; bus.operator = o; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        nb = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
            else if (bus.busy) nb++;
        end
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_busy_cycles"}, nb, eb);
        chk({tag, "_result"}, bus.result, er);
        chk({tag, "_remainder"}, bus.remainder, erem);
        chk({tag, "_overflow"}, bus.overflow, eov);
        chk({tag, "_div_by_zero"}, bus.div_by_zero, edz);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, bus.done, 1'b0);
        chk({tag, "_result_held"}, bus.result, er);
    endtask

    initial begin
        int nd, nb;
        logic [15:0] a, b;
        logic [1:0]  o;
        bus.start = 1'b0; bus.op1 = '0; bus.op2 = '0; bus.operator = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_result", bus.result, 16'd0);
        chk("rst_remainder", bus.remainder, 16'd0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_overflow", bus.overflow, 1'b0);
        chk("rst_dbz", bus.div_by_zero, 1'b0);

        run_op("add_25_17", 16'd25, 16'd17, 2'd0);
        run_op("sub_5_7", 16'd5, 16'd7, 2'd1);
        run_op("mul_300_300", 16'd300, 16'd300, 2'd2);
        run_op("div_999_7", 16'd999, 16'd7, 2'd3);
        run_op("div_1234_0", 16'd1234, 16'd0, 2'd3);
        run_op("add_wrap", 16'hFFFF, 16'd1, 2'd0);
        run_op("mul_max", 16'hFFFF, 16'hFFFF, 2'd2);
        run_op("div_max_1", 16'hFFFF, 16'd1, 2'd3);
        run_op("div_small_big", 16'd5, 16'hFFFF, 2'd3);
        run_op("div_zero_num", 16'd0, 16'd5, 2'd3);

        // operand/operator changes and a start pulse mid-divide must be ignored
        @(negedge clk);
        bus.op1 = 16'd60000; bus.op2 = 16'd3; bus.operator = 2'd3; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        nd = 0; nb = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 5) begin bus.op2 = 16'd9; bus.operator = 2'd0; bus.start = 1'b1; end
            if (c == 6) bus.start = 1'b0;
            if (bus.busy) nb++;
            if (bus.done) begin
                nd++;
                chk("div_60000_result", bus.result, 16'd20000);
                chk("div_60000_remainder", bus.remainder, 16'd0);
            end
        end
        chk("div_60000_done_count", nd, 1);
        chk("div_60000_busy_cycles", nb, 16);

        // reset in cycle 8 of a divide abandons it
        @(negedge clk);
        bus.op1 = 16'd999; bus.op2 = 16'd7; bus.operator = 2'd3; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_result", bus.result, 16'd0);
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("abort_no_done", nd, 0);
        run_op("add_1_1", 16'd1, 16'd1, 2'd0);

        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = $urandom_range(0, 5) == 0 ? 16'd0 :
                $urandom_range(0, 2) == 0 ? 16'($urandom_range(1, 31)) : 16'($urandom_range(0, 65535));
            o = 2'($urandom_range(0, 3));
            run_op($sformatf("rnd%0d_op%0d", i, o), a, b, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
